// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point sequential multiplier:
// default field widths, controller state encoding and exponent bias.
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2,
    PACK = 2'd3
  } fp_state_e;

  // Exponent bias for an exp_w-bit biased exponent field: 2^(exp_w-1)-1.
  function automatic int fp_bias(input int exp_w);
    return (32'sd1 <<< (exp_w - 1)) - 32'sd1;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational back end of the multiplier: takes the raw significand
// product, normalises it by at most one right shift, rounds to nearest
// even using guard/sticky, and applies zero/overflow/underflow handling.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                         sign,
  input  logic                         zero,
  input  logic signed [EXP_W+1:0]      exp_in,
  input  logic [2*MAN_W+1:0]           prod,
  output logic [EXP_W+MAN_W:0]         result,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int SE_W   = EXP_W + 2;
  localparam int PROD_W = 2 * MAN_W + 2;

  localparam logic signed [SE_W-1:0] EXP_ONES = SE_W'((32'sd1 <<< EXP_W) - 32'sd1);
  localparam logic signed [SE_W-1:0] EXP_ZERO = '0;
  localparam logic signed [SE_W-1:0] EXP_ONE  = SE_W'(32'sd1);

  logic [PROD_W-1:0]      norm_s;
  logic signed [SE_W-1:0] exp_n_s;
  logic                   unused_lead_s;
  logic [MAN_W-1:0]       frac_n_s;
  logic                   guard_s;
  logic                   sticky_s;
  logic                   round_up_s;
  logic [MAN_W+1:0]       sig_s;
  logic [MAN_W-1:0]       frac_r_s;
  logic signed [SE_W-1:0] exp_r_s;

  // Normalise: a product in [2,4) has its top bit set and needs one right shift.
  always_comb begin
    norm_s  = prod;
    exp_n_s = exp_in;
    if (prod[PROD_W-1]) begin
      norm_s  = prod;
      exp_n_s = exp_in + EXP_ONE;
    end else begin
      norm_s  = prod << 1;
      exp_n_s = exp_in;
    end
  end

  // Round to nearest, ties to even; a carry out of the significand renormalises.
  always_comb begin
    unused_lead_s = norm_s[PROD_W-1];
    frac_n_s      = norm_s[PROD_W-2 -: MAN_W];
    guard_s       = norm_s[MAN_W];
    sticky_s      = |norm_s[MAN_W-1:0];
    round_up_s    = guard_s & (sticky_s | frac_n_s[0]);
    sig_s         = {2'b01, frac_n_s} + {{(MAN_W+1){1'b0}}, round_up_s};
    frac_r_s      = sig_s[MAN_W-1:0];
    exp_r_s       = exp_n_s;
    if (sig_s[MAN_W+1]) begin
      frac_r_s = sig_s[MAN_W:1];
      exp_r_s  = exp_n_s + EXP_ONE;
    end else begin
      frac_r_s = sig_s[MAN_W-1:0];
      exp_r_s  = exp_n_s;
    end
  end

  // Exceptions: flushed zero operands, exponent saturation to infinity or zero.
  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (zero) begin
      result    = {sign, {(EXP_W+MAN_W){1'b0}}};
      overflow  = 1'b0;
      underflow = 1'b0;
    end else if (exp_r_s >= EXP_ONES) begin
      result    = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      overflow  = 1'b1;
      underflow = 1'b0;
    end else if (exp_r_s <= EXP_ZERO) begin
      result    = {sign, {(EXP_W+MAN_W){1'b0}}};
      overflow  = 1'b0;
      underflow = 1'b1;
    end else begin
      result    = {sign, exp_r_s[EXP_W-1:0], frac_r_s};
      overflow  = 1'b0;
      underflow = 1'b0;
    end
  end

endmodule

// File: rtl/fp_seq_multiplier.sv
// Sequential floating-point multiplier. Operands are latched on the
// accepting edge, significands are multiplied by radix-2 shift-add one
// bit per cycle, then the product is rounded and packed. Latency from
// the accepting edge to done is fixed at MAN_W+3 edges.
module fp_seq_multiplier
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int SE_W   = EXP_W + 2;
  localparam int CNT_W  = $clog2(SIG_W) + 1;

  localparam logic signed [SE_W-1:0] BIAS_S   = SE_W'(fp_bias(EXP_W));
  localparam logic [CNT_W-1:0]       ITER_LAST = CNT_W'(MAN_W);

  fp_state_e              state_r;
  fp_state_e              state_s;
  logic                   accept_s;
  logic [CNT_W-1:0]       iter_r;
  logic [SIG_W-1:0]       mcand_r;
  logic [PROD_W-1:0]      prod_r;
  logic [PROD_W-1:0]      prod_step_s;
  logic [SIG_W:0]         add_s;
  logic                   sign_r;
  logic                   zero_r;
  logic signed [SE_W-1:0] exp_r;
  logic signed [SE_W-1:0] exp_sum_s;
  logic [EXP_W-1:0]       a_exp_s;
  logic [EXP_W-1:0]       b_exp_s;

  logic                   busy_r;
  logic                   done_r;
  logic [W-1:0]           result_r;
  logic                   ovf_r;
  logic                   unf_r;

  logic [W-1:0]           pk_result_s;
  logic                   pk_ovf_s;
  logic                   pk_unf_s;
  logic [W-1:0]           pk_result_r;
  logic                   pk_ovf_r;
  logic                   pk_unf_r;

  // Controller next state; start is only honoured in IDLE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = MULT;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
          accept_s = 1'b0;
        end
      end
      MULT: begin
        if (iter_r == ITER_LAST) begin
          state_s = NORM;
        end else begin
          state_s = MULT;
        end
      end
      NORM:    state_s = PACK;
      PACK:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand field extraction and unbiased-sum exponent for the latched op.
  always_comb begin
    a_exp_s   = a[W-2:MAN_W];
    b_exp_s   = b[W-2:MAN_W];
    exp_sum_s = $signed({2'b00, a_exp_s}) + $signed({2'b00, b_exp_s}) - BIAS_S;
  end

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole product right.
  always_comb begin
    if (prod_r[0]) begin
      add_s = {1'b0, prod_r[PROD_W-1:SIG_W]} + {1'b0, mcand_r};
    end else begin
      add_s = {1'b0, prod_r[PROD_W-1:SIG_W]};
    end
    prod_step_s = {add_s, prod_r[SIG_W-1:1]};
  end

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign      (sign_r),
    .zero      (zero_r),
    .exp_in    (exp_r),
    .prod      (prod_r),
    .result    (pk_result_s),
    .overflow  (pk_ovf_s),
    .underflow (pk_unf_s)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      iter_r      <= '0;
      mcand_r     <= '0;
      prod_r      <= '0;
      sign_r      <= 1'b0;
      zero_r      <= 1'b0;
      exp_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= '0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
      pk_result_r <= '0;
      pk_ovf_r    <= 1'b0;
      pk_unf_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mcand_r <= {1'b1, a[MAN_W-1:0]};
            prod_r  <= {{SIG_W{1'b0}}, 1'b1, b[MAN_W-1:0]};
            sign_r  <= a[W-1] ^ b[W-1];
            zero_r  <= (a_exp_s == '0) || (b_exp_s == '0);
            exp_r   <= exp_sum_s;
            iter_r  <= '0;
            busy_r  <= 1'b1;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
          end
        end
        MULT: begin
          prod_r <= prod_step_s;
          iter_r <= iter_r + CNT_W'(1);
        end
        NORM: begin
          pk_result_r <= pk_result_s;
          pk_ovf_r    <= pk_ovf_s;
          pk_unf_r    <= pk_unf_s;
          iter_r      <= '0;
        end
        PACK: begin
          result_r <= pk_result_r;
          ovf_r    <= pk_ovf_r;
          unf_r    <= pk_unf_r;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign overflow  = ovf_r;
  assign underflow = unf_r;

endmodule

// File: tb/tb_fp_seq_multiplier.sv
// Self-checking bench: an arithmetic reference model plus an
// operation-timing model drive a per-cycle compare process, and directed
// vectors with hand-computed results pin both the model and the DUT.
module tb_fp_seq_multiplier;

  localparam int EW  = 8;
  localparam int MW  = 23;
  localparam int EW2 = 5;
  localparam int MW2 = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, overflow, underflow;
  logic [31:0] result;

  logic        start2;
  logic [15:0] a2, b2;
  logic        busy2, done2, ovf2, unf2;
  logic [15:0] result2;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected-behaviour model state
  logic        m_active, m_busy, m_done, m_ovf, m_unf;
  logic [31:0] m_res;
  int          m_cnt;
  logic [65:0] pend;

  always #5 clk = ~clk;

  fp_seq_multiplier #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .underflow(underflow)
  );

  fp_seq_multiplier #(.EXP_W(EW2), .MAN_W(MW2)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(result2),
    .overflow(ovf2), .underflow(unf2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product from exact integer arithmetic: {overflow, underflow, result}.
  function automatic logic [65:0] fp_model(input logic [63:0] x, input logic [63:0] y,
                                           input int ew, input int mw);
    longint unsigned fmask, emask, sx, sy, p, q, rem, half, sgn;
    longint ex, ey, e, emax;
    int nb, k;
    logic ovf, unf;
    logic [63:0] res;
    fmask = (64'd1 << mw) - 64'd1;
    emask = (64'd1 << ew) - 64'd1;
    emax  = longint'(emask);
    ex    = longint'((x >> mw) & emask);
    ey    = longint'((y >> mw) & emask);
    sgn   = ((x ^ y) >> (ew + mw)) & 64'd1;
    ovf = 1'b0;
    unf = 1'b0;
    if (ex == 0 || ey == 0) begin
      res = sgn << (ew + mw);
    end else begin
      sx = (64'd1 << mw) | (x & fmask);
      sy = (64'd1 << mw) | (y & fmask);
      p  = sx * sy;
      nb = 0;
      for (int i = 0; i < 64; i++) if (p[i]) nb = i + 1;
      k    = nb - (mw + 1);
      q    = p >> k;
      rem  = p - (q << k);
      half = 64'd1 << (k - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      e = ex + ey - ((longint'(1) << (ew - 1)) - 1) + longint'(nb - 1 - 2 * mw);
      if (q == (64'd1 << (mw + 1))) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= emax) begin
        res = (sgn << (ew + mw)) | (64'(emax) << mw);
        ovf = 1'b1;
      end else if (e <= 0) begin
        res = sgn << (ew + mw);
        unf = 1'b1;
      end else begin
        res = (sgn << (ew + mw)) | (64'(e) << mw) | (q & fmask);
      end
    end
    return {ovf, unf, res};
  endfunction

  // Operation timing model: accept in idle, done MW+3 edges later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_ovf    <= 1'b0;
      m_unf    <= 1'b0;
      m_res    <= 32'd0;
      m_cnt    <= 0;
      pend     <= 66'd0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == MW + 2) begin
          m_active <= 1'b0;
          m_busy   <= 1'b0;
          m_done   <= 1'b1;
          m_res    <= pend[31:0];
          m_ovf    <= pend[65];
          m_unf    <= pend[64];
        end
      end else if (start) begin
        m_active <= 1'b1;
        m_busy   <= 1'b1;
        m_cnt    <= 0;
        m_ovf    <= 1'b0;
        m_unf    <= 1'b0;
        pend     <= fp_model({32'd0, a}, {32'd0, b}, EW, MW);
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    check("cyc_done", {63'd0, done}, {63'd0, m_done});
    check("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
    check("cyc_result", {32'd0, result}, {32'd0, m_res});
    check("cyc_overflow", {63'd0, overflow}, {63'd0, m_ovf});
    check("cyc_underflow", {63'd0, underflow}, {63'd0, m_unf});
  end

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input string name,
                        input logic [31:0] exp_res, input logic exp_ovf, input logic exp_unf);
    int n;
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'd26);
    check({name, "_result"}, {32'd0, result}, {32'd0, exp_res});
    check({name, "_ovf"}, {63'd0, overflow}, {63'd0, exp_ovf});
    check({name, "_unf"}, {63'd0, underflow}, {63'd0, exp_unf});
  endtask

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic saw;
    logic [65:0] mv;
    rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
    start2 = 1'b0; a2 = 16'd0; b2 = 16'd0;

    // Hand-computed values pin the reference model.
    mv = fp_model(64'h41C26666, 64'hC0A00000, EW, MW);
    check("model_tie_even", mv, {2'b00, 64'hC2F30000});
    mv = fp_model(64'h7F000000, 64'h40000000, EW, MW);
    check("model_overflow", mv, {2'b10, 64'h7F800000});
    mv = fp_model(64'h00800000, 64'h00800000, EW, MW);
    check("model_underflow", mv, {2'b01, 64'h00000000});
    mv = fp_model(64'h3FFFFFFE, 64'h3F800001, EW, MW);
    check("model_round_carry", mv, {2'b00, 64'h40000000});
    mv = fp_model(64'h4000, 64'h4200, EW2, MW2);
    check("model_half", mv, {2'b00, 64'h4600});

    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_flags", {62'd0, overflow, underflow}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    run_op(32'h41C26666, 32'hC0A00000, "tie_even", 32'hC2F30000, 1'b0, 1'b0);
    run_op(32'h40000000, 32'h40400000, "two_x_three", 32'h40C00000, 1'b0, 1'b0);
    run_op(32'h00000000, 32'hC0A00000, "zero_neg", 32'h80000000, 1'b0, 1'b0);
    run_op(32'h7F000000, 32'h40000000, "overflow", 32'h7F800000, 1'b1, 1'b0);
    run_op(32'h40000000, 32'h40400000, "ovf_cleared", 32'h40C00000, 1'b0, 1'b0);
    run_op(32'h00800000, 32'h00800000, "underflow", 32'h00000000, 1'b0, 1'b1);
    run_op(32'h3FC00000, 32'h3FC00000, "one5_sq", 32'h40100000, 1'b0, 1'b0);
    run_op(32'hBF800000, 32'hBF800000, "neg_one_sq", 32'h3F800000, 1'b0, 1'b0);
    run_op(32'h3FFFFFFF, 32'h3FFFFFFF, "max_sig_sq", 32'h407FFFFE, 1'b0, 1'b0);
    run_op(32'h3FFFFFFE, 32'h3F800001, "round_carry", 32'h40000000, 1'b0, 1'b0);

    // Start while busy is ignored; reset mid-operation aborts with no done.
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = 32'h7F000000; b = 32'h7F000000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_mid_op", {63'd0, busy}, 64'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    check("abort_flags", {62'd0, overflow, underflow}, 64'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw = 1'b1;
    end
    check("no_done_after_abort", {63'd0, saw}, 64'd0);
    run_op(32'h40000000, 32'h40400000, "after_abort", 32'h40C00000, 1'b0, 1'b0);

    // Half-precision-style instance.
    @(negedge clk);
    a2 = 16'h4000; b2 = 16'h4200; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    n = 0;
    while (!done2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    mv = fp_model(64'h4000, 64'h4200, EW2, MW2);
    check("small_latency", 64'(n), 64'd13);
    check("small_result", {48'd0, result2}, 64'h4600);
    check("small_vs_model", {48'd0, result2}, mv[63:0]);
    check("small_flags", {62'd0, ovf2, unf2}, 64'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_seq_multiplier.md
FP_SEQ_MULTIPLIER -- requirements
Module: fp_seq_multiplier

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to accept a and b.
REQ-006 SHALL have port a, input, W, IEEE-style operand A (sign|exp|frac).
REQ-007 SHALL have port b, input, W, operand B, same format.
REQ-008 SHALL have port busy, output, 1, high while an operation is in flight.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when result is valid.
REQ-010 SHALL have port result, output, W, product, held until next accepted start.
REQ-011 SHALL have port overflow, output, 1, sticky per-operation overflow flag.
REQ-012 SHALL have port underflow, output, 1, sticky per-operation underflow flag.

Function
REQ-013 SHALL use FSM states IDLE, MULT, NORM, PACK; IDLE->MULT on start, MULT->NORM after MAN_W+1 iterations, NORM->PACK, PACK->IDLE.
REQ-014 SHALL accept start only in IDLE; start while busy is ignored, no side effects.
REQ-015 SHALL latch a and b on the accepting edge; later changes to a/b do not affect the operation.
REQ-016 SHALL form significands with a hidden 1 (MAN_W+1 bits) and multiply by radix-2 shift-add, one bit per cycle, using an internal iteration counter (no external step input).
REQ-017 SHALL assert done exactly MAN_W+3 rising edges after the accepting edge (26 for defaults), fixed for all operand values.
REQ-018 SHALL keep busy high from the edge after acceptance until the edge done asserts, inclusive of neither.
REQ-019 SHALL compute sign = sign(a) XOR sign(b) in every case, including zero results.
REQ-020 SHALL normalise the 2*(MAN_W+1)-bit product by at most one right shift and increment the exponent accordingly.
REQ-021 SHALL round to nearest, ties to even, using guard and sticky bits; rounding carry-out renormalises and increments the exponent.
REQ-022 SHALL treat an operand with exponent field 0 as zero (denormals flushed); result signed zero, flags 0.
REQ-023 SHALL, when biased exponent >= all-ones after rounding, output signed infinity (exp all-ones, frac 0) and set overflow.
REQ-024 SHALL, when biased exponent <= 0 after rounding, output signed zero and set underflow.
REQ-025 SHALL treat exponent all-ones inputs as ordinary large values (no NaN/Inf semantics); results follow REQ-023.
REQ-026 SHALL clear overflow and underflow on each accepted start; both update together with result at done.
REQ-027 SHALL accept a new start in the same cycle done is high (back-to-back ops, PACK->IDLE has no dead cycle beyond that).

Reset
REQ-028 SHALL, on rst high, immediately force state IDLE, busy 0, done 0, result 0, overflow 0, underflow 0, iteration counter 0.
REQ-029 SHALL abort any operation in flight on reset with no done pulse; first start after rst deasserts is accepted normally.

Structure
REQ-030 SHALL place default EXP_W, MAN_W, state encoding and bias computation (2^(EXP_W-1)-1) in shared package fp_pkg.
REQ-031 SHALL implement normalise/round/exception logic as sub-module fp_round_pack (combinational, parametrised by EXP_W, MAN_W), instanced once.

Verification
REQ-032 SHALL check a=0x41C26666 (24.3), b=0xC0A00000 (-5) -> result 0xC2F30000 (tie rounded to even), flags 0, done at edge 26.
REQ-033 SHALL check a=0x40000000, b=0x40400000 -> result 0x40C00000; then a=0x00000000, b=0xC0A00000 -> 0x80000000.
REQ-034 SHALL check a=0x7F000000, b=0x40000000 -> result 0x7F800000, overflow 1; next op 2.0*3.0 clears overflow.
REQ-035 SHALL check a=0x00800000, b=0x00800000 -> result 0x00000000, underflow 1.
REQ-036 SHALL check start pulsed at cycle 5 of an op (ignored), and rst asserted at cycle 10 -> outputs zero, no done; subsequent 2.0*3.0 completes correctly.
REQ-037 SHALL run one case at EXP_W=5, MAN_W=10: a=0x4000 (2.0), b=0x4200 (3.0) -> result 0x4600, done at edge 13.
